// File: rtl/rv_mem_pkg.sv
// Shared definitions for the RV32I memory-access stage:
// funct3 access-size encodings and the load wait-state FSM states.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_access_data_mem.sv
// Byte-enable data RAM: asynchronous read, synchronous write.
// Ports: clk_i, addr_i (word index), we_i (byte strobe), wdata_i, rdata_o.
module data_mem #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [3:0]        we_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_access.sv
// RV32I memory-access stage: loads/stores against the data RAM, MEM/WB
// register, and a load wait-state FSM driving MEM_STALL.
// Inputs: clk, rst, EX_MEM_* (address, store data, rd, controls, funct3).
// Outputs: MEM_WB_* registered bundle, MEM_STALL, MEM_MISALIGN.
// Optional macro MEM_MISALIGN_CHECK_EN: trap misaligned half/word accesses.
module mem_access
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int LOAD_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_MEM_ALU_OUT,
    input  logic [31:0] EX_MEM_RS2_DATA,
    input  logic [4:0]  EX_MEM_RD,
    input  logic        EX_MEM_regwrite_en,
    input  logic        EX_MEM_wb_sel,
    input  logic        EX_MEM_mem_read,
    input  logic        EX_MEM_mem_write,
    input  logic [2:0]  EX_MEM_funct3,
    output logic [31:0] MEM_WB_ALU_OUT,
    output logic [31:0] MEM_WB_LOAD_ALU_OUT,
    output logic [4:0]  MEM_WB_RD,
    output logic        MEM_WB_regwrite_en,
    output logic        MEM_WB_wb_sel,
    output logic        MEM_STALL,
    output logic        MEM_MISALIGN
);

    localparam logic [1:0] WAIT_N = LOAD_WAIT[1:0];

    logic [1:0]        lane;
    logic [ADDR_W-1:0] widx;
    logic              unused_hi;
    logic              load_req;
    logic              st_valid;
    logic              mis;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic [31:0]       rshift;
    logic [15:0]       half_sel;
    logic [31:0]       ld_ext;

    assign lane      = EX_MEM_ALU_OUT[1:0];
    assign widx      = EX_MEM_ALU_OUT[ADDR_W+1:2];
    // Upper address bits wrap; they are intentionally unused.
    assign unused_hi = ^EX_MEM_ALU_OUT[31:ADDR_W+2];

    // Read and write both high is a store.
    assign load_req = EX_MEM_mem_read & ~EX_MEM_mem_write;
    assign st_valid = EX_MEM_mem_write &
                      ((EX_MEM_funct3 == F3_B) |
                       (EX_MEM_funct3 == F3_H) |
                       (EX_MEM_funct3 == F3_W));

`ifdef MEM_MISALIGN_CHECK_EN
    logic acc;
    logic is_half;
    logic is_word;
    logic mis_q;

    // Halfword: x01; word (incl. loads treated as LW): x1x.
    assign acc     = load_req | st_valid;
    assign is_half = acc & ~EX_MEM_funct3[1] & EX_MEM_funct3[0];
    assign is_word = acc & EX_MEM_funct3[1];
    assign mis     = (is_half & lane[0]) | (is_word & (|lane));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else if (mis) begin
            mis_q <= 1'b1;
        end
    end

    assign MEM_MISALIGN = mis_q;
`else
    assign mis          = 1'b0;
    assign MEM_MISALIGN = 1'b0;
`endif

    always_comb begin
        be    = 4'b0000;
        wdata = EX_MEM_RS2_DATA;
        if (st_valid & ~mis) begin
            unique case (EX_MEM_funct3)
                F3_B: begin
                    be    = 4'b0001 << lane;
                    wdata = {4{EX_MEM_RS2_DATA[7:0]}};
                end
                F3_H: begin
                    be    = lane[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{EX_MEM_RS2_DATA[15:0]}};
                end
                default: begin
                    be    = 4'b1111;
                    wdata = EX_MEM_RS2_DATA;
                end
            endcase
        end
    end

    data_mem #(
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk_i   (clk),
        .addr_i  (widx),
        .we_i    (be),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    assign rshift   = rdata >> {lane, 3'b000};
    assign half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        unique case (EX_MEM_funct3)
            F3_B:    ld_ext = {{24{rshift[7]}}, rshift[7:0]};
            F3_H:    ld_ext = {{16{half_sel[15]}}, half_sel};
            F3_BU:   ld_ext = {24'd0, rshift[7:0]};
            F3_HU:   ld_ext = {16'd0, half_sel};
            default: ld_ext = rdata;
        endcase
    end

    mem_state_e state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       stall;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (load_req & ~mis & (WAIT_N != 2'd0)) begin
                    stall   = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = 2'd1;
                end
            end
            default: begin
                if (cnt_q != WAIT_N) begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 2'd1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 2'd0;
                end
            end
        endcase
    end

    // Nothing advances while reset is held.
    assign MEM_STALL = stall & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q             <= ST_IDLE;
            cnt_q               <= 2'd0;
            MEM_WB_ALU_OUT      <= 32'd0;
            MEM_WB_LOAD_ALU_OUT <= 32'd0;
            MEM_WB_RD           <= 5'd0;
            MEM_WB_regwrite_en  <= 1'b0;
            MEM_WB_wb_sel       <= 1'b0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            MEM_WB_LOAD_ALU_OUT <= ld_ext;
            if (stall) begin
                // Bubble: ALU value and wb_sel hold.
                MEM_WB_RD          <= 5'd0;
                MEM_WB_regwrite_en <= 1'b0;
            end else begin
                MEM_WB_ALU_OUT     <= EX_MEM_ALU_OUT;
                MEM_WB_RD          <= EX_MEM_RD;
                MEM_WB_regwrite_en <= EX_MEM_regwrite_en & ~mis;
                MEM_WB_wb_sel      <= EX_MEM_wb_sel;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access (LOAD_WAIT = 2) against a byte-array
// reference model; honours MEM_MISALIGN_CHECK_EN when defined.
module tb_mem_access;

    localparam int AW = 10;
    localparam int LW = 2;
    localparam int NB = 4 * (2**AW);

    logic        clk, rst;
    logic [31:0] alu_i, rs2_i;
    logic [4:0]  rd_i;
    logic        rwe_i, wbs_i, rdn_i, wrn_i;
    logic [2:0]  f3_i;
    logic [31:0] wb_alu, wb_ld;
    logic [4:0]  wb_rd;
    logic        wb_rwe, wb_wbs, stall_o, mis_o;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] ld;
        logic [4:0]  rd;
        logic        rwe;
        logic        wbs;
        logic        mis;
        logic [3:0]  stall;
        logic [3:0]  bub;
    } res_t;

    logic [7:0] mm [NB];
    logic       mis_m;
    int         tests_run;
    int         tests_failed;

    mem_access #(.ADDR_W(AW), .LOAD_WAIT(LW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .EX_MEM_ALU_OUT      (alu_i),
        .EX_MEM_RS2_DATA     (rs2_i),
        .EX_MEM_RD           (rd_i),
        .EX_MEM_regwrite_en  (rwe_i),
        .EX_MEM_wb_sel       (wbs_i),
        .EX_MEM_mem_read     (rdn_i),
        .EX_MEM_mem_write    (wrn_i),
        .EX_MEM_funct3       (f3_i),
        .MEM_WB_ALU_OUT      (wb_alu),
        .MEM_WB_LOAD_ALU_OUT (wb_ld),
        .MEM_WB_RD           (wb_rd),
        .MEM_WB_regwrite_en  (wb_rwe),
        .MEM_WB_wb_sel       (wb_wbs),
        .MEM_STALL           (stall_o),
        .MEM_MISALIGN        (mis_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] m_read(input logic [31:0] a,
                                           input logic [2:0] f3);
        int y = int'(a[AW+1:0]);
        int b = y & ~3;
        int h = b + 2 * int'(a[1]);
        logic [31:0] w = {mm[b+3], mm[b+2], mm[b+1], mm[b]};
        logic [15:0] hw = {mm[h+1], mm[h]};
        case (f3)
            3'b000:  return {{24{mm[y][7]}}, mm[y]};
            3'b001:  return {{16{hw[15]}}, hw};
            3'b100:  return {24'd0, mm[y]};
            3'b101:  return {16'd0, hw};
            default: return w;
        endcase
    endfunction

    function automatic res_t model(input logic rdn, input logic wrn,
                                   input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] d,
                                   input logic [4:0] rd,
                                   input logic rwe, input logic wbs);
        res_t r;
        int y = int'(a[AW+1:0]);
        int b = y & ~3;
        int h = b + 2 * int'(a[1]);
        logic ldq = rdn && !wrn;
        logic st = wrn && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        logic mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        if (st || ldq) begin
            if (f3 == 3'b001 || f3 == 3'b101) mis = a[0];
            else if (f3 == 3'b000 || f3 == 3'b100) mis = 1'b0;
            else mis = (a[1:0] != 2'b00);
        end
`endif
        r.ld = m_read(a, f3);
        if (st && !mis) begin
            case (f3)
                3'b000: mm[y] = d[7:0];
                3'b001: begin
                    mm[h] = d[7:0];
                    mm[h+1] = d[15:8];
                end
                default: begin
                    mm[b] = d[7:0];
                    mm[b+1] = d[15:8];
                    mm[b+2] = d[23:16];
                    mm[b+3] = d[31:24];
                end
            endcase
        end
        mis_m   = mis_m | mis;
        r.alu   = a;
        r.rd    = rd;
        r.rwe   = rwe && !mis;
        r.wbs   = wbs;
        r.mis   = mis_m;
        r.stall = (ldq && !mis) ? 4'(LW) : 4'd0;
        r.bub   = 4'd0;
        return r;
    endfunction

    // Drives one instruction from a negedge, holds it through any stall,
    // and samples the MEM/WB outputs at the negedge after it commits.
    task automatic issue(input logic rdn, input logic wrn,
                         input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd,
                         input logic rwe, input logic wbs,
                         output res_t o);
        int n = 0;
        int bub = 0;
        rdn_i = rdn; wrn_i = wrn; f3_i = f3; alu_i = a;
        rs2_i = d; rd_i = rd; rwe_i = rwe; wbs_i = wbs;
        #1;
        while (stall_o === 1'b1 && n < 8) begin
            n++;
            @(posedge clk);
            @(negedge clk);
            if (wb_rwe !== 1'b0 || wb_rd !== 5'd0) bub++;
        end
        @(posedge clk);
        @(negedge clk);
        o.alu   = wb_alu;
        o.ld    = wb_ld;
        o.rd    = wb_rd;
        o.rwe   = wb_rwe;
        o.wbs   = wb_wbs;
        o.mis   = mis_o;
        o.stall = 4'(n);
        o.bub   = 4'(bub);
    endtask

    task automatic step(input logic rdn, input logic wrn,
                        input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rd,
                        input logic rwe, input logic wbs,
                        output res_t o, output res_t e);
        e = model(rdn, wrn, f3, a, d, rd, rwe, wbs);
        issue(rdn, wrn, f3, a, d, rd, rwe, wbs, o);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rdn_i = 0; wrn_i = 0; f3_i = 0; alu_i = 0;
        rs2_i = 0; rd_i = 0; rwe_i = 0; wbs_i = 0;
        mis_m = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({wb_alu, wb_ld, wb_rd, wb_rwe, wb_wbs, stall_o, mis_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset: got %h %h %h %b %b %b %b, required all 0",
                     wb_alu, wb_ld, wb_rd, wb_rwe, wb_wbs, stall_o, mis_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_init();
        res_t o, e;
        for (int w = 0; w < 16; w++) begin
            step(0, 1, 3'b010, 32'(w * 4), $urandom, 5'd0, 0, 0, o, e);
            tests_run++;
            if ({o.alu, o.stall, o.bub, o.rwe} !== {e.alu, e.stall, e.bub, e.rwe}) begin
                tests_failed++;
                $display("FAIL init_sw%0d: got %h, required %h", w, o, e);
            end
        end
    endtask

    task automatic test_word();
        res_t o, e;
        step(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0, o, e);
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL sw: got %h, required %h", o, e);
        end
        step(1, 0, 3'b010, 32'h10, 32'h0, 5'd5, 1, 1, o, e);
        tests_run++;
        if (o !== e || o.ld !== 32'hDEADBEEF || o.wbs !== 1'b1 || o.rwe !== 1'b1) begin
            tests_failed++;
            $display("FAIL lw: got %h, required %h (ld DEADBEEF)", o, e);
        end
    endtask

    task automatic test_byte();
        res_t o, e;
        logic [31:0] want [3];
        logic [2:0]  f3s  [3];
        want[0] = 32'hFFFFFF80; want[1] = 32'h00000080; want[2] = 32'h80ADBEEF;
        f3s[0] = 3'b000; f3s[1] = 3'b100; f3s[2] = 3'b010;
        step(0, 1, 3'b000, 32'h13, 32'h00000080, 5'd0, 0, 0, o, e);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, f3s[i], (i == 2) ? 32'h10 : 32'h13, 0, 5'd6, 1, 1, o, e);
            tests_run++;
            if (o !== e || o.ld !== want[i]) begin
                tests_failed++;
                $display("FAIL byte%0d: got %h, required %h ld %h", i, o, e, want[i]);
            end
        end
    endtask

    task automatic test_half();
        res_t o, e;
        logic [31:0] want [3];
        logic [2:0]  f3s  [3];
        want[0] = 32'hFFFF8001; want[1] = 32'h00008001; want[2] = 32'h8001BEEF;
        f3s[0] = 3'b001; f3s[1] = 3'b101; f3s[2] = 3'b010;
        step(0, 1, 3'b001, 32'h12, 32'h00008001, 5'd0, 0, 0, o, e);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, f3s[i], (i == 2) ? 32'h10 : 32'h12, 0, 5'd8, 1, 1, o, e);
            tests_run++;
            if (o !== e || o.ld !== want[i]) begin
                tests_failed++;
                $display("FAIL half%0d: got %h, required %h ld %h", i, o, e, want[i]);
            end
        end
    endtask

    task automatic test_wait();
        res_t o, e;
        step(1, 0, 3'b010, 32'h10, 0, 5'd7, 1, 1, o, e);
        tests_run++;
        if (o !== e || o.stall !== 4'd2 || o.bub !== 4'd0 || o.rd !== 5'd7) begin
            tests_failed++;
            $display("FAIL wait: got %h, required %h (2 stalls)", o, e);
        end
    endtask

    task automatic test_alias();
        res_t o, e;
        step(1, 1, 3'b010, 32'h10 + 32'(4 * (2**AW)), 32'h12345678, 5'd0, 0, 0, o, e);
        tests_run++;
        if (o !== e || o.stall !== 4'd0) begin
            tests_failed++;
            $display("FAIL alias_st: got %h, required %h", o, e);
        end
        step(1, 0, 3'b010, 32'h10, 0, 5'd4, 1, 1, o, e);
        tests_run++;
        if (o !== e || o.ld !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL alias_ld: got %h, required %h", o, e);
        end
    endtask

    task automatic test_random();
        res_t o, e;
        for (int i = 0; i < 150; i++) begin
            int k = $urandom_range(0, 3);
            logic [31:0] a = ($urandom << 6) | 32'($urandom_range(0, 63));
            logic rdn = (k == 1) || (k == 3);
            logic wrn = (k == 0) || (k == 3);
            step(rdn, wrn, 3'($urandom), a, $urandom, 5'($urandom),
                 1'($urandom), 1'($urandom), o, e);
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL rand%0d k%0d: got %h, required %h", i, k, o, e);
            end
        end
    endtask

`ifdef MEM_MISALIGN_CHECK_EN
    task automatic test_misalign();
        res_t o, e;
        step(0, 1, 3'b010, 32'h10, 32'h0BADC0DE, 5'd0, 0, 0, o, e);
        step(0, 1, 3'b010, 32'h11, 32'hCAFEF00D, 5'd3, 1, 0, o, e);
        tests_run++;
        if (o !== e || o.mis !== 1'b1 || o.rwe !== 1'b0) begin
            tests_failed++;
            $display("FAIL mis_sw: got %h, required %h", o, e);
        end
        step(1, 0, 3'b010, 32'h12, 0, 5'd3, 1, 1, o, e);
        tests_run++;
        if (o !== e || o.stall !== 4'd0 || o.rwe !== 1'b0) begin
            tests_failed++;
            $display("FAIL mis_lw: got %h, required %h", o, e);
        end
        step(1, 0, 3'b010, 32'h10, 0, 5'd3, 1, 1, o, e);
        tests_run++;
        if (o !== e || o.ld !== 32'h0BADC0DE || o.mis !== 1'b1) begin
            tests_failed++;
            $display("FAIL mis_sticky: got %h, required %h", o, e);
        end
    endtask
`endif

    task automatic test_reset_mid_wait();
        res_t o, e;
        rdn_i = 1; wrn_i = 0; f3_i = 3'b010; alu_i = 32'h10;
        rs2_i = 0; rd_i = 5'd9; rwe_i = 1; wbs_i = 1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (stall_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL in_wait: got stall %b, required 1", stall_o);
        end
        rst = 1'b1;
        mis_m = 1'b0;
        #1;
        tests_run++;
        if ({wb_alu, wb_ld, wb_rd, wb_rwe, wb_wbs, stall_o, mis_o} !== '0) begin
            tests_failed++;
            $display("FAIL rst_wait: got %h %h %h %b %b %b %b, required all 0",
                     wb_alu, wb_ld, wb_rd, wb_rwe, wb_wbs, stall_o, mis_o);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 3'b100, 32'h11, 0, 5'd9, 1, 1, o, e);
        tests_run++;
        if (o !== e || o.stall !== 4'd2) begin
            tests_failed++;
            $display("FAIL after_rst: got %h, required %h", o, e);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_init();
        test_word();
        test_byte();
        test_half();
        test_wait();
        test_alias();
        test_random();
`ifdef MEM_MISALIGN_CHECK_EN
        test_misalign();
`endif
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the pipelined RV32I core, sitting between the EX/MEM register and the write-back stage. It owns the byte-addressable data memory and performs RV32I loads (byte/half/word, signed/unsigned) and stores (byte/half/word). It registers the MEM/WB pipeline values consumed by write-back. A configurable load wait-state counter stalls the front of the pipeline while a slow load completes.

## Interface
- ADDR_W, 10: word-address width; memory holds 2**ADDR_W 32-bit words.
- LOAD_WAIT, 0: extra cycles per load, range 0..3.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- EX_MEM_ALU_OUT  in  32  ALU result; this is the byte address for loads and stores.
- EX_MEM_RS2_DATA  in  32  store data.
- EX_MEM_RD  in  5  destination register.
- EX_MEM_regwrite_en  in  1  register write enable.
- EX_MEM_wb_sel  in  1  write-back select: 0 = ALU result, 1 = load data.
- EX_MEM_mem_read  in  1  load request.
- EX_MEM_mem_write  in  1  store request.
- EX_MEM_funct3  in  3  access size and sign.
- MEM_WB_ALU_OUT  out  32  registered ALU result.
- MEM_WB_LOAD_ALU_OUT  out  32  registered, extended load data.
- MEM_WB_RD  out  5  registered destination register.
- MEM_WB_regwrite_en  out  1  registered write enable.
- MEM_WB_wb_sel  out  1  registered write-back select.
- MEM_STALL  out  1  combinational; upstream stages hold while it is high.
- MEM_MISALIGN  out  1  sticky misaligned-access flag.

## Operation
**Addressing**
- Word index is EX_MEM_ALU_OUT[ADDR_W+1:2].
- Address bits above ADDR_W+1 are ignored, so accesses wrap modulo the memory size.
- Byte lane is EX_MEM_ALU_OUT[1:0].

**Stores** (active when mem_write = 1):
- funct3 000 = SB: writes rs2[7:0] into the addressed byte lane.
- funct3 001 = SH: writes rs2[15:0] into lanes {a[1],0} and {a[1],1}.
- funct3 010 = SW: writes the full word.
- Any other funct3 value: no write.
- If mem_read and mem_write are both high, the access is treated as a store and the read is ignored.

**Loads**
- Memory read is combinational from the array; the selected lane is extended before registering.
- LB (000) and LH (001) sign-extend.
- LBU (100) and LHU (101) zero-extend.
- LW (010) returns the full word.
- funct3 011, 110 and 111 are treated as LW.

**Pass-through**
- MEM_WB_ALU_OUT, RD, regwrite_en and wb_sel register the corresponding EX_MEM inputs every non-stalled cycle.
- MEM_WB_LOAD_ALU_OUT is updated every cycle. For non-loads its value is don't-care but deterministic: the extended read of the addressed word.

**Wait-state FSM** (states IDLE, WAIT; wait_cnt is 2 bits)
- IDLE, load present, LOAD_WAIT > 0:
  - MEM_STALL = 1.
  - Go to WAIT with wait_cnt ← 1.
  - MEM_WB registers a bubble: regwrite_en ← 0, RD ← 0.
- WAIT, wait_cnt ≠ LOAD_WAIT:
  - MEM_STALL = 1.
  - wait_cnt increments.
  - Bubble is registered.
- WAIT, wait_cnt = LOAD_WAIT:
  - MEM_STALL = 0.
  - Load commits to MEM_WB.
  - Go to IDLE with wait_cnt ← 0.
- LOAD_WAIT = 0: the FSM never leaves IDLE and MEM_STALL stays 0.
- Stores never stall.
- While MEM_STALL is high, upstream holds all EX_MEM inputs stable. Changing them during a stall is illegal.

## Timing
- Reset values:
  - All MEM_WB outputs are 0 and MEM_MISALIGN is 0.
  - FSM is in IDLE with wait_cnt = 0, so MEM_STALL = 0.
  - Memory contents are not reset.
- Latency: a load or ALU result entering in cycle T appears on MEM_WB outputs after the edge ending cycle T+LOAD_WAIT. Stores and ALU operations appear after the edge ending cycle T.
- Store write: the array updates on the edge ending cycle T.
  - A load of the same address in cycle T+1 returns the new data.
  - A load of the same address in cycle T (a different instruction is not possible in the same cycle) is not applicable.
- Reset asserted mid-WAIT: the FSM aborts to IDLE and the pending load is discarded.

## Configuration
Macro `MEM_MISALIGN_CHECK_EN`.

With the macro defined, a halfword access with a[0] = 1, or a word access with a[1:0] ≠ 0:
- suppresses the store;
- forces MEM_WB_regwrite_en ← 0;
- skips wait states;
- sets MEM_MISALIGN = 1, which stays high until reset.

Without the macro:
- low address bits are ignored for alignment: halfword uses a[1], word uses the whole word;
- MEM_MISALIGN is tied to 0.

## Structure
- Package rv_mem_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the FSM state enum (ST_IDLE, ST_WAIT).
- Sub-module data_mem: byte-enable RAM with a 4-bit write strobe, asynchronous read and synchronous write.
- Lane steering and extension stay in mem_access.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 → MEM_WB_LOAD_ALU_OUT = 0xDEADBEEF, wb_sel = 1, regwrite_en = 1.
- SB 0x80 to 0x13, then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; the other three bytes of the word are unchanged.
- SH 0x8001 to 0x12, then LH 0x12 → 0xFFFF8001; LHU 0x12 → 0x00008001.
- LOAD_WAIT = 2, LW issued → MEM_STALL high for exactly 2 cycles, two bubbles with regwrite_en = 0, data committed on the 3rd edge.
- Address 0x10 + 4·2**ADDR_W → aliases to word 4; mem_read and mem_write both high → store performed.
- With `MEM_MISALIGN_CHECK_EN`, SW to 0x11 → memory unchanged, MEM_MISALIGN = 1 and sticky; reset asserted mid-WAIT → MEM_STALL = 0 and outputs = 0.
